// File: rtl/digit_counter_pkg.sv
// Shared types and constants for the four-digit run/stop counter.
// Build option: define DIGIT_COUNTER_BCD_EN for decimal digits (0-9);
// leave it undefined for hex digits (0-F).
package digit_counter_pkg;

    // Run/stop control states.
    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } run_state_t;

`ifdef DIGIT_COUNTER_BCD_EN
    localparam logic [3:0] DIG_MAX = 4'h9;
`else
    localparam logic [3:0] DIG_MAX = 4'hF;
`endif

    localparam int NUM_DIGITS = 4;

    // Result of stepping one digit: new value plus carry/borrow out.
    typedef struct packed {
        logic [3:0] value;
        logic       carry;
    } digit_step_t;

    // Step one digit by +1 or -1 when enabled; carry marks a wrap.
    function automatic digit_step_t step_digit(input logic [3:0] value,
                                               input logic       down,
                                               input logic       en);
        digit_step_t r;
        r.value = value;
        r.carry = 1'b0;
        if (en) begin
            if (down) begin
                if (value == 4'h0) begin
                    r.value = DIG_MAX;
                    r.carry = 1'b1;
                end else begin
                    r.value = value - 4'h1;
                end
            end else begin
                if (value >= DIG_MAX) begin
                    r.value = 4'h0;
                    r.carry = 1'b1;
                end else begin
                    r.value = value + 4'h1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, level debouncer and a
// one-cycle press pulse on the accepted 1->0 (pressed) transition.
module key_debounce #(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic press
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             level_q;
    logic [CNT_W-1:0] cnt_q;

    // Synchronize the raw key, accept a new level after DB_CYCLES stable cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press   <= 1'b0;
        end else begin
            // NOTE: non-blocking so each flop takes its pre-edge input; blocking would collapse the synchronizer chain.
            sync_q <= {sync_q[0], key};
            press  <= 1'b0;
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q   <= '0;
                level_q <= sync_q[1];
                // Only the released->pressed change produces an event.
                press   <= level_q;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/digit_counter.sv
// Four-digit up/down counter with debounced run/stop and clear keys.
// Build option: DIGIT_COUNTER_BCD_EN selects decimal digits, otherwise hex.
module digit_counter
    import digit_counter_pkg::*;
#(
    parameter int CLK_HZ    = 50000000,
    parameter int TICK_HZ   = 10,
    parameter int DB_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_run,
    input  logic       key_clr,
    input  logic       sw_down,
    output logic [3:0] dig0,
    output logic [3:0] dig1,
    output logic [3:0] dig2,
    output logic [3:0] dig3,
    output logic       run,
    output logic       wrap
);

    localparam int PRESC_LAST_INT = (CLK_HZ / TICK_HZ > 1) ? CLK_HZ / TICK_HZ - 1 : 0;
    localparam int PRESC_W = (PRESC_LAST_INT > 0) ? $clog2(PRESC_LAST_INT + 1) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC_LAST_INT);

    logic run_press;
    logic clr_press;

    run_state_t state_q;
    run_state_t state_d;

    logic [PRESC_W-1:0] presc_q;
    logic               tick;

    logic [NUM_DIGITS-1:0][3:0] digit_q;
    logic [NUM_DIGITS-1:0][3:0] digit_d;
    logic                       wrap_d;
    logic                       carry;
    digit_step_t                step;

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key_run (
        .clk   (clk),
        .rst_n (rst_n),
        .key   (key_run),
        .press (run_press)
    );

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key_clr (
        .clk   (clk),
        .rst_n (rst_n),
        .key   (key_clr),
        .press (clr_press)
    );

    // Run/stop state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STOP;
        end else begin
            state_q <= state_d;
        end
    end

    // Each run press toggles between STOP and RUN; clear never affects it.
    always_comb begin
        // NOTE: default first so every path assigns state_d; a missing branch would infer a latch.
        state_d = state_q;
        if (run_press) begin
            state_d = (state_q == STOP) ? RUN : STOP;
        end
    end

    assign tick = (state_q == RUN) && (presc_q == PRESC_LAST);

    // Prescaler: advances only while running, held in STOP, zeroed by clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else if (clr_press) begin
            presc_q <= '0;
        end else if (state_q == RUN) begin
            presc_q <= tick ? '0 : presc_q + PRESC_W'(1);
        end
    end

    // Ripple the tick through all digits in one cycle; carry out of the top digit is a wrap.
    always_comb begin
        digit_d = digit_q;
        carry   = tick;
        step    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            step       = step_digit(digit_q[i], sw_down, carry);
            digit_d[i] = step.value;
            carry      = step.carry;
        end
        wrap_d = carry;
    end

    // Registered digits and wrap pulse; clear wins over a coincident tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= '0;
            wrap    <= 1'b0;
        end else if (clr_press) begin
            digit_q <= '0;
            wrap    <= 1'b0;
        end else begin
            digit_q <= digit_d;
            wrap    <= wrap_d;
        end
    end

    assign dig0 = digit_q[0];
    assign dig1 = digit_q[1];
    assign dig2 = digit_q[2];
    assign dig3 = digit_q[3];
    assign run  = (state_q == RUN);

endmodule

// File: tb/tb_digit_counter.sv
// Self-checking bench for digit_counter with a behavioural model:
// the count is a plain integer modulo BASE^4, keys are judged on a window
// of raw samples, and expected digits come from integer division.
module tb_digit_counter;

    localparam int CLK_HZ    = 1000;
    localparam int TICK_HZ   = 100;
    localparam int DB_CYCLES = 4;
    localparam int PERIOD    = CLK_HZ / TICK_HZ;
`ifdef DIGIT_COUNTER_BCD_EN
    localparam int BASE = 10;
`else
    localparam int BASE = 16;
`endif
    localparam int TOTAL = BASE * BASE * BASE * BASE;
    localparam logic [15:0] ALL_MAX = (BASE == 10) ? 16'h9999 : 16'hFFFF;
    localparam logic [15:0] LOW_MAX = (BASE == 10) ? 16'h0009 : 16'h000F;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       key_run = 1'b1;
    logic       key_clr = 1'b1;
    logic       sw_down = 1'b0;
    logic [3:0] dig0, dig1, dig2, dig3;
    logic       run, wrap;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    digit_counter #(
        .CLK_HZ    (CLK_HZ),
        .TICK_HZ   (TICK_HZ),
        .DB_CYCLES (DB_CYCLES)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_run (key_run),
        .key_clr (key_clr),
        .sw_down (sw_down),
        .dig0    (dig0),
        .dig1    (dig1),
        .dig2    (dig2),
        .dig3    (dig3),
        .run     (run),
        .wrap    (wrap)
    );

    wire [15:0] dut_digits = {dig3, dig2, dig1, dig0};

    // ---------------- reference model ----------------
    bit                 m_run, m_wrap, pend_run, pend_clr, acc_run, acc_clr;
    int                 m_count, m_phase;
    logic [DB_CYCLES:0] hist_run, hist_clr;

    wire m_tick = m_run && (m_phase == PERIOD - 1);

    // True when the DB_CYCLES raw samples seen through the 2-stage delay all equal v.
    function automatic bit window_is(input logic [DB_CYCLES:0] h, input bit v);
        for (int i = 1; i <= DB_CYCLES; i++) begin
            if (h[i] !== v) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [15:0] expected_digits(input int value);
        logic [15:0] r;
        int          v;
        r = '0;
        v = value;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(v % BASE);
            v = v / BASE;
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run    <= 1'b0;
            m_wrap   <= 1'b0;
            m_count  <= 0;
            m_phase  <= 0;
            pend_run <= 1'b0;
            pend_clr <= 1'b0;
            acc_run  <= 1'b1;
            acc_clr  <= 1'b1;
            hist_run <= '1;
            hist_clr <= '1;
        end else begin
            if (pend_clr) begin
                m_count <= 0;
                m_phase <= 0;
                m_wrap  <= 1'b0;
            end else begin
                m_wrap <= m_tick && (sw_down ? (m_count == 0) : (m_count == TOTAL - 1));
                if (m_tick) m_count <= sw_down ? (m_count + TOTAL - 1) % TOTAL : (m_count + 1) % TOTAL;
                if (m_run) m_phase <= (m_phase + 1) % PERIOD;
            end
            if (pend_run) m_run <= !m_run;
            pend_run <= acc_run && window_is(hist_run, 1'b0);
            pend_clr <= acc_clr && window_is(hist_clr, 1'b0);
            if (window_is(hist_run, !acc_run)) acc_run <= !acc_run;
            if (window_is(hist_clr, !acc_clr)) acc_clr <= !acc_clr;
            hist_run <= {hist_run[DB_CYCLES-1:0], key_run};
            hist_clr <= {hist_clr[DB_CYCLES-1:0], key_clr};
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic advance(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit on_run, input bit on_clr, input int hold);
        if (on_run) key_run = 1'b0;
        if (on_clr) key_clr = 1'b0;
        advance(hold);
        key_run = 1'b1;
        key_clr = 1'b1;
        advance(DB_CYCLES + 4);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        n_checks++;
        if (dut_digits !== 16'h0000) begin n_fail++; $display("FAIL reset_digits: got %h want 0000", dut_digits); end
        n_checks++;
        if (run !== 1'b0) begin n_fail++; $display("FAIL reset_run: got %b want 0", run); end
        n_checks++;
        if (wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %b want 0", wrap); end
        @(negedge clk);
        rst_n = 1'b1;
        advance(5);
        n_checks++;
        if (run !== 1'b0 || dut_digits !== 16'h0000) begin
            n_fail++; $display("FAIL after_reset: run %b digits %h want 0 0000", run, dut_digits);
        end
    endtask

    task automatic test_run_press;
        key_run = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            advance(1);
            if (c == 10) key_run = 1'b1;
            n_checks++;
            if (run !== (c >= 7)) begin
                n_fail++; $display("FAIL run_latency: cycle %0d run %b want %b", c, run, (c >= 7));
            end
            if (c == 16 || c == 17) begin
                n_checks++;
                if (dig0 !== ((c == 17) ? 4'd1 : 4'd0)) begin
                    n_fail++; $display("FAIL first_tick: cycle %0d dig0 %0d want %0d", c, dig0, (c == 17) ? 1 : 0);
                end
            end
        end
        n_checks++;
        if (dut_digits !== expected_digits(m_count) || run !== m_run) begin
            n_fail++; $display("FAIL run_model: digits %h run %b want %h %b", dut_digits, run, expected_digits(m_count), m_run);
        end
    endtask

    task automatic test_bounce;
        int   toggles;
        logic prev_run;
        toggles  = 0;
        prev_run = run;
        for (int i = 0; i < 20 + 12 + DB_CYCLES + 4; i++) begin
            if (i < 20)       key_run = ((i / 2) % 2 == 1);
            else if (i < 32)  key_run = 1'b0;
            else              key_run = 1'b1;
            advance(1);
            if (run !== prev_run) toggles++;
            prev_run = run;
        end
        n_checks++;
        if (toggles != 1) begin n_fail++; $display("FAIL bounce_toggles: got %0d want 1", toggles); end
        n_checks++;
        if (run !== 1'b0 || run !== m_run) begin n_fail++; $display("FAIL bounce_state: run %b want 0", run); end
    endtask

    task automatic test_count_up_down;
        press(1'b0, 1'b1, DB_CYCLES + 4);
        press(1'b1, 1'b0, DB_CYCLES + 4);
        sw_down = 1'b0;
        for (int i = 0; i < PERIOD * (BASE + 4) && m_count != BASE - 1; i++) advance(1);
        n_checks++;
        if (dut_digits !== LOW_MAX) begin n_fail++; $display("FAIL up_low_max: got %h want %h", dut_digits, LOW_MAX); end
        for (int i = 0; i < PERIOD * 2 && m_count != BASE; i++) advance(1);
        n_checks++;
        if (dut_digits !== 16'h0010 || wrap !== 1'b0) begin
            n_fail++; $display("FAIL up_carry: got %h wrap %b want 0010 0", dut_digits, wrap);
        end
        sw_down = 1'b1;
        for (int i = 0; i < PERIOD * 2 && m_count != BASE - 1; i++) advance(1);
        n_checks++;
        if (dut_digits !== LOW_MAX) begin n_fail++; $display("FAIL down_borrow: got %h want %h", dut_digits, LOW_MAX); end
        for (int i = 0; i < PERIOD * (BASE + 4) && m_count != TOTAL - 1; i++) advance(1);
        n_checks++;
        if (dut_digits !== ALL_MAX || wrap !== 1'b1) begin
            n_fail++; $display("FAIL down_wrap: got %h wrap %b want %h 1", dut_digits, wrap, ALL_MAX);
        end
        advance(1);
        n_checks++;
        if (wrap !== 1'b0 || dut_digits !== ALL_MAX) begin
            n_fail++; $display("FAIL down_wrap_width: wrap %b digits %h want 0 %h", wrap, dut_digits, ALL_MAX);
        end
        sw_down = 1'b0;
        for (int i = 0; i < PERIOD * 2 && m_count != 0; i++) advance(1);
        n_checks++;
        if (dut_digits !== 16'h0000 || wrap !== 1'b1) begin
            n_fail++; $display("FAIL up_wrap: got %h wrap %b want 0000 1", dut_digits, wrap);
        end
        advance(1);
        n_checks++;
        if (wrap !== 1'b0) begin n_fail++; $display("FAIL up_wrap_width: wrap %b want 0", wrap); end
    endtask

    task automatic test_clear_on_tick;
        sw_down = 1'b0;
        press(1'b0, 1'b1, DB_CYCLES + 4);
        for (int i = 0; i < PERIOD * (4 * BASE + 8) && !(m_count == 4 * BASE + 2 && m_phase == 3); i++) advance(1);
        n_checks++;
        if (!(m_count == 4 * BASE + 2 && m_phase == 3)) begin
            n_fail++; $display("FAIL clear_setup_timeout: count %0d phase %0d want %0d 3", m_count, m_phase, 4 * BASE + 2);
        end
        key_clr = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            advance(1);
            if (c == 6) begin
                n_checks++;
                if (dut_digits !== 16'h0042) begin n_fail++; $display("FAIL clear_pre: got %h want 0042", dut_digits); end
            end
            if (c == 7) begin
                n_checks++;
                if (dut_digits !== 16'h0000 || wrap !== 1'b0 || run !== 1'b1) begin
                    n_fail++; $display("FAIL clear_vs_tick: digits %h wrap %b run %b want 0000 0 1", dut_digits, wrap, run);
                end
            end
        end
        key_clr = 1'b1;
        advance(DB_CYCLES + 4);
        n_checks++;
        if (dut_digits !== expected_digits(m_count)) begin
            n_fail++; $display("FAIL clear_after: got %h want %h", dut_digits, expected_digits(m_count));
        end
    endtask

    task automatic test_run_clear_together;
        key_run = 1'b0;
        key_clr = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            advance(1);
            if (c == 6) begin
                n_checks++;
                if (run !== 1'b1) begin n_fail++; $display("FAIL both_pre: run %b want 1", run); end
            end
            if (c == 7) begin
                n_checks++;
                if (run !== 1'b0 || dut_digits !== 16'h0000) begin
                    n_fail++; $display("FAIL both_events: run %b digits %h want 0 0000", run, dut_digits);
                end
            end
        end
        key_run = 1'b1;
        key_clr = 1'b1;
        advance(DB_CYCLES + 4);
    endtask

    task automatic test_random;
        int rl, cl;
        rl = 0;
        cl = 0;
        for (int i = 0; i < 3000; i++) begin
            if (rl == 0) begin key_run = 1'($urandom_range(0, 1)); rl = int'($urandom_range(1, 12)); end
            if (cl == 0) begin key_clr = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1; cl = int'($urandom_range(1, 12)); end
            rl--;
            cl--;
            if ($urandom_range(0, 49) == 0) sw_down = !sw_down;
            advance(1);
            n_checks++;
            if ({dut_digits, run, wrap} !== {expected_digits(m_count), m_run, m_wrap}) begin
                n_fail++;
                $display("FAIL random: step %0d digits %h run %b wrap %b want %h %b %b",
                         i, dut_digits, run, wrap, expected_digits(m_count), m_run, m_wrap);
            end
        end
        key_run = 1'b1;
        key_clr = 1'b1;
        sw_down = 1'b0;
        advance(DB_CYCLES + 4);
    endtask

    task automatic test_reset_midcount;
        if (!m_run) press(1'b1, 1'b0, DB_CYCLES + 4);
        press(1'b0, 1'b1, DB_CYCLES + 4);
        for (int i = 0; i < PERIOD * (BASE * BASE + 2 * BASE + 8) && m_count != BASE * BASE + 2 * BASE + 3; i++) advance(1);
        n_checks++;
        if (dut_digits !== 16'h0123 || run !== 1'b1) begin
            n_fail++; $display("FAIL preload_0123: digits %h run %b want 0123 1", dut_digits, run);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (dut_digits !== 16'h0000 || run !== 1'b0 || wrap !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: digits %h run %b wrap %b want 0000 0 0", dut_digits, run, wrap);
        end
        @(negedge clk);
        rst_n = 1'b1;
        advance(12);
        n_checks++;
        if (run !== 1'b0 || dut_digits !== 16'h0000) begin
            n_fail++; $display("FAIL stop_after_reset: run %b digits %h want 0 0000", run, dut_digits);
        end
        // Key already held when reset releases: exactly one event.
        #2;
        rst_n   = 1'b0;
        key_run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            advance(1);
            if (c == 6 || c == 7) begin
                n_checks++;
                if (run !== (c == 7)) begin
                    n_fail++; $display("FAIL held_key_event: cycle %0d run %b want %b", c, run, (c == 7));
                end
            end
        end
        key_run = 1'b1;
        advance(DB_CYCLES + 6);
        n_checks++;
        if (run !== 1'b1 || run !== m_run) begin n_fail++; $display("FAIL held_key_once: run %b want 1", run); end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_run_press();
        test_bounce();
        test_count_up_down();
        test_clear_on_tick();
        test_run_clear_together();
        test_random();
        test_reset_midcount();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/digit_counter.md
DIGIT_COUNTER -- requirements
Module: digit_counter

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50000000, meaning the CLK frequency in Hz.
REQ-002 The block SHALL have parameter TICK_HZ, default 10, meaning the count rate in Hz while running.
REQ-003 The block SHALL have parameter DB_CYCLES, default 500000, meaning the number of stable CLK cycles required to accept a key level.
REQ-004 CLK  in  1  system clock; all state changes on its rising edge.
REQ-005 RST_N  in  1  asynchronous, active-low reset; one clock domain only.
REQ-006 KEY_RUN  in  1  raw pushbutton, active-low (pressed = 0), asynchronous to CLK; each press toggles run/stop.
REQ-007 KEY_CLR  in  1  raw pushbutton, active-low, asynchronous; each press clears all digits.
REQ-008 SW_DOWN  in  1  count direction: 0 = up, 1 = down; sampled at each tick.
REQ-009 DIG0..DIG3  out  4 each  digit values for downstream 7-segment decoders; DIG0 is least significant.
REQ-010 RUN  out  1  1 while in state RUN.
REQ-011 WRAP  out  1  single-cycle pulse on the cycle the 4-digit value wraps (max->0 up, 0->max down).

Function
REQ-012 Each key SHALL pass through a 2-flop synchronizer and then a debouncer that changes its output only after DB_CYCLES consecutive cycles of an unchanged synchronized level.
REQ-013 A press event SHALL be a 1-cycle pulse on the debounced 1->0 transition; release SHALL generate no event; a held key SHALL generate exactly one event.
REQ-014 The run FSM SHALL have states STOP and RUN: a run event toggles STOP->RUN or RUN->STOP; no other transitions exist.
REQ-015 The prescaler SHALL count 0..(CLK_HZ/TICK_HZ - 1) only in RUN and emit a 1-cycle tick at the terminal count; entering STOP SHALL hold it, and a clear event SHALL zero it.
REQ-016 On a tick, DIG0 SHALL step ±1; a digit carries/borrows into the next on wrap; the count ripples across all four digits within that same cycle.
REQ-017 The digit maximum SHALL be 4'hF (hex mode) or 4'h9 (decimal mode, see Configuration); digit values SHALL never exceed the maximum.
REQ-018 WRAP SHALL assert in the cycle after the tick that moves 4'hFFFF/9999 -> 0 (up) or 0 -> max (down).
REQ-019 A clear event SHALL set all digits to 0 on the next cycle, SHALL take priority over a coincident tick (no step, no WRAP), and SHALL NOT change the FSM state.
REQ-020 Coincident run and clear events SHALL both take effect in the same cycle.
REQ-021 Outputs SHALL be registered; digit latency from tick to output SHALL be 1 cycle.

Reset
REQ-022 While RST_N = 0: DIG0..DIG3 = 0, RUN = 0, WRAP = 0, FSM = STOP, prescaler = 0, synchronizers and debouncers = released (1), debounce counters = 0.
REQ-023 Reset asserted mid-count or mid-debounce SHALL abort immediately; after deassertion, a key already held low SHALL produce one event after DB_CYCLES+2 cycles.

Configuration
REQ-024 Macro DIGIT_COUNTER_BCD_EN: when defined, the digit maximum is 9 (decimal 0000-9999); when undefined, it is F (hex 0000-FFFF).

Structure
REQ-025 A shared package digit_counter_pkg SHALL hold the FSM state typedef (STOP, RUN) and the digit-maximum constant selected by the macro.
REQ-026 A sub-module key_debounce (synchronizer + debouncer + press-pulse) SHALL be instantiated once per key.

Verification (CLK_HZ=1000, TICK_HZ=100, DB_CYCLES=4)
REQ-027 Reset, then press KEY_RUN for 10 cycles -> RUN=1 exactly 7 cycles after the falling edge; DIG0 = 1 after a further 10 cycles.
REQ-028 KEY_RUN bouncing 0/1 every 2 cycles for 20 cycles, then held low -> exactly one toggle.
REQ-029 Hex build: preload count to 000F (run 15 ticks) and tick -> DIG1=1, DIG0=0; from FFFF, tick -> 0000 with WRAP high for 1 cycle.
REQ-030 BCD build: SW_DOWN=1 from 0000 and tick -> 9999 with WRAP pulse; from 0010, tick -> 0009.
REQ-031 Clear event coincident with tick at 0042 -> 0000 next cycle, no WRAP, RUN unchanged.
REQ-032 Drop RST_N while RUN with count 0123 -> all outputs 0 asynchronously; after release, FSM remains in STOP.
